// File: rtl/vga_timing_receiver.sv
// vga_timing_receiver: recovers pixel coordinates, data enable and timing lock from an incoming VGA hsync/vsync/RGB stream.
module vga_timing_receiver #(
  parameter int H_VIS       = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_VIS       = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int LOCK_FRAMES = 2
) (
  input  logic       clk,
  input  logic       i_rst_n,
  input  logic       i_hsync,
  input  logic       i_vsync,
  input  logic [3:0] i_red,
  input  logic [3:0] i_green,
  input  logic [3:0] i_blue,
  output logic [9:0] o_x,
  output logic [9:0] o_y,
  output logic       o_de,
  output logic [3:0] o_red,
  output logic [3:0] o_green,
  output logic [3:0] o_blue,
  output logic       o_locked,
  output logic       o_frame_start,
  output logic       o_err
);
  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
  localparam logic [9:0] H_LEN  = 10'(H_TOTAL);
  localparam logic [9:0] H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0] H_LOAD = 10'(H_VIS + H_FP);
  localparam logic [9:0] H_ACT  = 10'(H_VIS);
  localparam logic [9:0] V_LEN  = 10'(V_TOTAL);
  localparam logic [9:0] V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0] V_LOAD = 10'(V_VIS + V_FP);
  localparam logic [9:0] V_ACT  = 10'(V_VIS);
  localparam logic [3:0] GOOD_N = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

  state_t     state;
  logic       hs_s1, vs_s1, hs_hist, vs_hist;
  logic [3:0] red_s1, green_s1, blue_s1;
  logic [9:0] line_len, line_cnt;
  logic [3:0] good;
  logic       meas, line_ok;

  logic       hfall, vfall, hwrap, line_bad, frame_ok, lost, good_hit, locked_n, de_n;
  logic [9:0] x_n, y_n, len_n, cnt_n;

  always_comb begin
    hfall    = hs_hist & ~hs_s1;
    vfall    = vs_hist & ~vs_s1;
    hwrap    = !hfall && o_x == H_MAX;
    x_n      = hfall ? H_LOAD : hwrap ? 10'd0 : o_x + 10'd1;
    y_n      = vfall ? V_LOAD : !hwrap ? o_y : o_y == V_MAX ? 10'd0 : o_y + 10'd1;
    len_n    = hfall ? 10'd1 : line_len == '1 ? line_len : line_len + 10'd1;
    cnt_n    = vfall ? {9'd0, hfall} : (hfall && line_cnt != '1) ? line_cnt + 10'd1 : line_cnt;
    // the first hsync fall after leaving SEARCH has no valid start point, so meas gates it
    line_bad = hfall && meas && line_len != H_LEN;
    frame_ok = line_ok && !line_bad && line_cnt == V_LEN;
    good_hit = state == VERIFY && vfall && frame_ok && good + 4'd1 == GOOD_N;
    lost     = state == LOCKED && ((hfall && line_len != H_LEN) || (vfall && line_cnt != V_LEN) || line_len == '1);
    locked_n = !lost && (state == LOCKED || good_hit);
    de_n     = locked_n && x_n < H_ACT && y_n < V_ACT;
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      hs_s1         <= 1'b1;
      vs_s1         <= 1'b1;
      hs_hist       <= 1'b1;
      vs_hist       <= 1'b1;
      red_s1        <= '0;
      green_s1      <= '0;
      blue_s1       <= '0;
      line_len      <= '0;
      line_cnt      <= '0;
      good          <= '0;
      meas          <= 1'b0;
      line_ok       <= 1'b0;
      state         <= SEARCH;
      o_x           <= '0;
      o_y           <= '0;
      o_de          <= 1'b0;
      o_red         <= '0;
      o_green       <= '0;
      o_blue        <= '0;
      o_locked      <= 1'b0;
      o_frame_start <= 1'b0;
      o_err         <= 1'b0;
    end else begin
      hs_s1         <= i_hsync;
      vs_s1         <= i_vsync;
      hs_hist       <= hs_s1;
      vs_hist       <= vs_s1;
      red_s1        <= i_red;
      green_s1      <= i_green;
      blue_s1       <= i_blue;
      line_len      <= len_n;
      line_cnt      <= cnt_n;
      meas          <= state != SEARCH && (meas || hfall);
      line_ok       <= vfall || (line_ok && !line_bad);
      o_x           <= x_n;
      o_y           <= y_n;
      o_de          <= de_n;
      o_red         <= de_n ? red_s1 : 4'd0;
      o_green       <= de_n ? green_s1 : 4'd0;
      o_blue        <= de_n ? blue_s1 : 4'd0;
      o_locked      <= locked_n;
      o_frame_start <= locked_n && x_n == 10'd0 && y_n == 10'd0;
      o_err         <= lost;
      case (state)
        SEARCH: if (vfall) begin
          state <= VERIFY;
          good  <= '0;
        end
        VERIFY: if (vfall) begin
          state <= !frame_ok ? SEARCH : good_hit ? LOCKED : VERIFY;
          good  <= good + 4'd1;
        end
        LOCKED: if (lost) state <= SEARCH;
        default: state <= SEARCH;
      endcase
    end
  end
endmodule

// File: tb/tb_vga_timing_receiver.sv
// tb_vga_timing_receiver: random-colour VGA streams with timing faults, checked against a timestamp-based reference model.
module tb_vga_timing_receiver;
  // shrunken raster keeps several locked frames well inside the cycle budget
  localparam int HV = 16, HF = 4, HS = 6, HB = 6;
  localparam int VV = 12, VF = 2, VS = 2, VB = 4;
  localparam int LF = 2;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic [1:0] tag;
  } pix_t;

  localparam pix_t IDLE = '{hs: 1'b1, vs: 1'b1, r: 4'h0, g: 4'h0, b: 4'h0, tag: 2'd0};

  logic       clk = 1'b0, i_rst_n = 1'b1, i_hsync = 1'b1, i_vsync = 1'b1;
  logic [3:0] i_red = '0, i_green = '0, i_blue = '0;
  logic [9:0] o_x, o_y;
  logic       o_de, o_locked, o_frame_start, o_err;
  logic [3:0] o_red, o_green, o_blue;

  vga_timing_receiver #(
    .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .LOCK_FRAMES(LF)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_hsync(i_hsync), .i_vsync(i_vsync),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .o_x(o_x), .o_y(o_y), .o_de(o_de), .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_locked(o_locked), .o_frame_start(o_frame_start), .o_err(o_err)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int err_cnt = 0, vf_since = 0, lock_vf_exp = 3, de_cnt = 0;
  bit prev_locked = 0, ever_locked = 0, de_cont = 0;
  pix_t s1, drv;

  // reference model state: timestamps of sync falls rather than running counters
  int c, x, y, last_hf, nlines, phase, good, c_ver;
  bit hp, vp, clean;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    c = 0; x = 0; y = 0; last_hf = 1; nlines = 0; phase = 0; good = 0; c_ver = 0;
    hp = 1; vp = 1; clean = 0;
    s1 = IDLE; drv = IDLE;
    prev_locked = 0; de_cont = 0; vf_since = 0;
  endtask

  task automatic step(input pix_t p, output logic [35:0] e);
    bit hf, vf, wrap, lost, de, lk;
    int llen, lc;
    c++;
    hf = hp && !p.hs;
    vf = vp && !p.vs;
    hp = p.hs;
    vp = p.vs;
    llen = (c - last_hf > 1023) ? 1023 : c - last_hf;
    lc = (nlines > 1023) ? 1023 : nlines;
    x = hf ? HV + HF : (x + 1) % HT;
    wrap = !hf && x == 0;
    if (vf) y = VV + VF;
    else if (wrap) y = (y + 1) % VT;
    if (hf && last_hf > c_ver && llen != HT) clean = 0;
    lost = 0;
    if (phase == 0) begin
      if (vf) begin phase = 1; good = 0; c_ver = c; end
    end else if (phase == 1) begin
      if (vf) begin
        if (clean && lc == VT) begin good++; if (good == LF) phase = 2; end
        else phase = 0;
      end
    end else if ((hf && llen != HT) || (vf && lc != VT) || llen == 1023) begin
      phase = 0;
      lost = 1;
    end
    if (vf) clean = 1;
    if (hf) last_hf = c;
    nlines = vf ? int'(hf) : nlines + int'(hf);
    lk = phase == 2;
    de = lk && x < HV && y < VV;
    e = {10'(x), 10'(y), de, de ? p.r : 4'h0, de ? p.g : 4'h0, de ? p.b : 4'h0,
         lk, lk && x == 0 && y == 0, lost};
  endtask

  task automatic tick(input pix_t p);
    logic [35:0] e;
    @(negedge clk);
    step(s1, e);
    check("cycle", {o_x, o_y, o_de, o_red, o_green, o_blue, o_locked, o_frame_start, o_err}, e);
    if (s1.tag == 2'd1)
      check("rgb_pin", {o_x, o_y, o_de, o_red, o_green, o_blue, o_frame_start},
            {10'd0, 10'd0, 1'b1, 4'hA, 4'h5, 4'hC, 1'b1});
    if (s1.tag == 2'd2) check("vfall_xy", {o_x, o_y}, {10'd0, 10'(VV + VF)});
    if (o_err) begin
      err_cnt++;
      vf_since = 0;
      check("err_unlock", o_locked, 1'b0);
    end
    if (o_locked && !prev_locked) check("lock_vfalls", vf_since, lock_vf_exp);
    ever_locked |= o_locked;
    if (o_frame_start) begin
      if (de_cont) check("de_per_frame", de_cnt, HV * VV);
      de_cnt = 0;
      de_cont = 1;
    end
    if (!o_locked) de_cont = 0;
    if (o_de) de_cnt++;
    prev_locked = o_locked;
    if (drv.vs && !p.vs) vf_since++;
    s1 = drv;
    drv = p;
    i_hsync = p.hs; i_vsync = p.vs; i_red = p.r; i_green = p.g; i_blue = p.b;
  endtask

  task automatic run_frame(input int lines, input int bad_line, input int bad_len,
                           input bit dead, input bit rgb_pin, input int stop_line);
    pix_t p;
    int len, vs0;
    vs0 = lines - VS - VB;
    for (int yy = 0; yy < lines; yy++) begin
      if (yy == stop_line) return;
      len = (yy == bad_line) ? bad_len : HT;
      for (int xx = 0; xx < len; xx++) begin
        p.hs = dead || !(xx >= HV + HF && xx < HV + HF + HS);
        p.vs = dead || !(yy >= vs0 && yy < vs0 + VS);
        p.r = 4'($urandom);
        p.g = 4'($urandom);
        p.b = 4'($urandom);
        p.tag = 2'd0;
        if (rgb_pin && xx == 0 && yy == 0) begin
          p.r = 4'hA; p.g = 4'h5; p.b = 4'hC; p.tag = 2'd1;
        end
        if (!dead && xx == 0 && yy == vs0) p.tag = 2'd2;
        tick(p);
      end
    end
  endtask

  task automatic do_reset();
    #2 i_rst_n = 1'b0;
    i_hsync = 1'b1; i_vsync = 1'b1; i_red = '0; i_green = '0; i_blue = '0;
    #1 check("reset_outputs", {o_x, o_y, o_de, o_red, o_green, o_blue, o_locked, o_frame_start, o_err}, 36'd0);
    repeat (2) @(negedge clk);
    check("reset_hold", {o_x, o_y, o_de, o_red, o_green, o_blue, o_locked, o_frame_start, o_err}, 36'd0);
    i_rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int e0;
    do_reset();
    lock_vf_exp = 3;
    for (int f = 0; f < 5; f++) run_frame(VT, -1, HT, 0, f >= 3, -1);
    check("locked_nominal", o_locked, 1'b1);
    check("no_err_nominal", err_cnt, 0);

    e0 = err_cnt;
    run_frame(VT, int'($urandom_range(1, 10)), HT - 1, 0, 0, -1);
    check("short_line_err", err_cnt - e0, 1);
    for (int f = 0; f < 4; f++) run_frame(VT, -1, HT, 0, f == 3, -1);
    check("relock_line", o_locked, 1'b1);

    e0 = err_cnt;
    run_frame(VT, -1, HT, 1, 0, -1);
    run_frame(VT, -1, HT, 1, 0, -1);
    check("dead_hsync_err", err_cnt - e0, 1);
    check("dead_hsync_unlocked", o_locked, 1'b0);
    for (int f = 0; f < 4; f++) run_frame(VT, -1, HT, 0, 0, -1);
    check("relock_dead", o_locked, 1'b1);

    do_reset();
    lock_vf_exp = 5;
    ever_locked = 0;
    e0 = err_cnt;
    run_frame(VT, -1, HT, 0, 0, -1);
    run_frame(VT - 1, -1, HT, 0, 0, -1);
    check("short_frame_no_err", err_cnt - e0, 0);
    check("short_frame_no_lock", ever_locked, 1'b0);
    for (int f = 0; f < 4; f++) run_frame(VT, -1, HT, 0, 0, -1);
    check("relock_frame", o_locked, 1'b1);

    lock_vf_exp = 3;
    run_frame(VT, -1, HT, 0, 0, 8);
    do_reset();
    for (int f = 0; f < 4; f++) run_frame(VT, -1, HT, 0, f == 3, -1);
    check("relock_reset", o_locked, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
